map_index_fetch: RTL and testbench

//  Upstream feeder of the map palette stage in the frame decoder. Per visible pixel from VGA

---
 rtl/map_pkg.sv | 20 ++
 rtl/map_index_fetch_if.sv | 13 +
 rtl/map_addr_gen.sv | 30 +++
 rtl/map_index_fetch.sv | 121 ++++++++++++
 tb/tb_map_index_fetch.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/map_pkg.sv
// Shared constants and types for the map index fetch stage: map geometry in cells,
// packing of colour indices into memory words, and the palette index type.
package map_pkg;

  localparam int CELL_LOG2     = 3;
  localparam int MAP_W         = 256;
  localparam int MAP_H         = 60;
  localparam int PIX_PER_WORD  = 4;
  localparam int WORDS_PER_ROW = MAP_W / PIX_PER_WORD;

  typedef logic [3:0] pal_idx_t;

  localparam pal_idx_t SKY_INDEX = 4'd0;

  // Nibble k of a packed map word is bits [4k+3:4k].
  function automatic pal_idx_t nibble_sel(input logic [15:0] word, input logic [1:0] nib);
    return word[{nib, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/map_index_fetch_if.sv
// Read port of the packed tile-map memory: one-cycle synchronous read, 4 indices per word.
interface map_index_fetch_if #(
  parameter int ADDR_W = 12
);

  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       rdata;

  modport master (output rd, output addr, input rdata);
  modport slave  (input rd, input addr, output rdata);

endinterface

// File: rtl/map_addr_gen.sv
// Maps a screen pixel plus horizontal scroll onto a map-memory word address, the nibble
// within that word, and an out-of-bounds flag for pixels that fall off the map.
module map_addr_gen
  import map_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic [15:0]       i_shadow,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_nib,
  output logic              o_oob
);

  logic [16:0] mx;
  logic [16:0] cell_x;
  logic [9:0]  cell_y;

  always_comb begin
    // 17-bit sum: large scrolls push the pixel past the map edge rather than wrapping.
    mx     = {7'd0, i_x} + {1'b0, i_shadow};
    cell_x = mx >> CELL_LOG2;
    cell_y = i_y >> CELL_LOG2;
    o_oob  = (cell_x >= 17'(MAP_W)) || (cell_y >= 10'(MAP_H));
    o_addr = ADDR_W'(32'(cell_y) * WORDS_PER_ROW + 32'(cell_x >> 2));
    o_nib  = cell_x[1:0];
  end

endmodule

// File: rtl/map_index_fetch.sv
// Per-pixel tile-map lookup: scroll shadow, address issue, 1-cycle memory read and nibble
// select, with hsync/vsync carried alongside so everything leaves 3 cycles after entry.
module map_index_fetch
  import map_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_start,
  input  logic                i_pix_valid,
  input  logic [9:0]          i_x,
  input  logic [9:0]          i_y,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic [15:0]         i_scroll_x,
  map_index_fetch_if.master   mem,
  output logic                o_valid,
  output pal_idx_t            o_index,
  output logic                o_hs,
  output logic                o_vs
);

  logic [ADDR_W-1:0] gen_addr;
  logic [1:0]        gen_nib;
  logic              gen_oob;

  logic [15:0]       shadow_q, shadow_d;
  logic              v1_q, v1_d, oob1_q, oob1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [1:0]        nib1_q, nib1_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              v2_q, v2_d, oob2_q, oob2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [1:0]        nib2_q, nib2_d;
  logic              valid_q, valid_d, hs_q, hs_d, vs_q, vs_d;
  pal_idx_t          index_q, index_d;

  map_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_x      (i_x),
    .i_y      (i_y),
    .i_shadow (shadow_q),
    .o_addr   (gen_addr),
    .o_nib    (gen_nib),
    .o_oob    (gen_oob)
  );

  always_comb begin
    // NOTE: every signal written here gets an unconditional value on every path, so no latch is inferred.
    shadow_d = i_frame_start ? i_scroll_x : shadow_q;

    v1_d     = i_pix_valid;
    nib1_d   = gen_nib;
    oob1_d   = gen_oob;
    hs1_d    = i_hs;
    vs1_d    = i_vs;
    rd_d     = i_pix_valid & ~gen_oob;
    addr_d   = rd_d ? gen_addr : addr_q;

    v2_d     = v1_q;
    nib2_d   = nib1_q;
    oob2_d   = oob1_q;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;

    // Read data is valid in this stage; invalid and off-map pixels both show the sky index.
    valid_d  = v2_q;
    index_d  = (v2_q && !oob2_q) ? nibble_sel(mem.rdata, nib2_q) : SKY_INDEX;
    hs_d     = hs2_q;
    vs_d     = vs2_q;
  end

  // NOTE: the whole pipeline is reset, not just the valids, so sync outputs come up at idle level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= '0;
      v1_q     <= 1'b0;
      nib1_q   <= '0;
      oob1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      v2_q     <= 1'b0;
      nib2_q   <= '0;
      oob2_q   <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      valid_q  <= 1'b0;
      index_q  <= SKY_INDEX;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      shadow_q <= shadow_d;
      v1_q     <= v1_d;
      nib1_q   <= nib1_d;
      oob1_q   <= oob1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      v2_q     <= v2_d;
      nib2_q   <= nib2_d;
      oob2_q   <= oob2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      valid_q  <= valid_d;
      index_q  <= index_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign mem.rd   = rd_q;
  assign mem.addr = addr_q;
  assign o_valid  = valid_q;
  assign o_index  = index_q;
  assign o_hs     = hs_q;
  assign o_vs     = vs_q;

endmodule

// File: tb/tb_map_index_fetch.sv
// Self-checking bench for map_index_fetch: directed scroll/OOB/sync/reset cases followed by
// randomized pixels, compared against a per-pixel model of the map lookup.
module tb_map_index_fetch;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_frame_start;
  logic        i_pix_valid;
  logic [9:0]  i_x;
  logic [9:0]  i_y;
  logic        i_hs;
  logic        i_vs;
  logic [15:0] i_scroll_x;
  logic        o_valid;
  logic [3:0]  o_index;
  logic        o_hs;
  logic        o_vs;

  map_index_fetch_if #(.ADDR_W(12)) mem_if ();

  map_index_fetch #(.ADDR_W(12)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_frame_start (i_frame_start),
    .i_pix_valid   (i_pix_valid),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_hs          (i_hs),
    .i_vs          (i_vs),
    .i_scroll_x    (i_scroll_x),
    .mem           (mem_if),
    .o_valid       (o_valid),
    .o_index       (o_index),
    .o_hs          (o_hs),
    .o_vs          (o_vs)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Tile-map memory: synchronous read, data available the cycle after the strobe.
  logic [15:0] mem_arr [4096];
  always @(posedge i_clk) begin
    if (mem_if.rd) mem_if.rdata <= mem_arr[mem_if.addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [3:0]  idx;
    logic        hs;
    logic        vs;
    logic        rd;
    logic [11:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          model_shadow;
  logic [11:0] model_last_addr;

  function automatic exp_t idle_entry();
    exp_t e;
    e.valid = 1'b0; e.idx = 4'd0; e.hs = 1'b1; e.vs = 1'b1; e.rd = 1'b0; e.addr = 12'd0;
    return e;
  endfunction

  // Present one pixel for one cycle; outputs seen now belong to the pixel of 3 steps ago,
  // the memory strobe/address to the pixel of the previous step.
  task automatic step(input logic valid, input int x, input int y, input logic fs,
                      input logic [15:0] scroll, input logic hs, input logic vs);
    exp_t e;
    int   mx, cx, cy, word;
    logic oob;
    i_pix_valid   = valid;
    i_x           = 10'(x);
    i_y           = 10'(y);
    i_frame_start = fs;
    i_scroll_x    = scroll;
    i_hs          = hs;
    i_vs          = vs;

    mx  = x + model_shadow;
    cx  = mx / 8;
    cy  = y / 8;
    oob = (cx >= 256) || (cy >= 60);
    e.valid = valid;
    e.hs    = hs;
    e.vs    = vs;
    e.rd    = valid && !oob;
    e.idx   = 4'd0;
    if (e.rd) begin
      word            = cy * 64 + cx / 4;
      model_last_addr = 12'(word);
      e.idx           = 4'((mem_arr[word] >> (4 * (cx % 4))) & 16'hF);
    end
    e.addr = model_last_addr;
    if (fs) model_shadow = int'(scroll);

    @(negedge i_clk);
    check("mem_rd",   {31'd0, mem_if.rd},   {31'd0, exp_q[$].rd});
    check("mem_addr", {20'd0, mem_if.addr}, {20'd0, exp_q[$].addr});
    check("o_valid",  {31'd0, o_valid},     {31'd0, exp_q[0].valid});
    check("o_index",  {28'd0, o_index},     {28'd0, exp_q[0].idx});
    check("o_hs",     {31'd0, o_hs},        {31'd0, exp_q[0].hs});
    check("o_vs",     {31'd0, o_vs},        {31'd0, exp_q[0].vs});
    void'(exp_q.pop_front());
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 16'd0, 1'b1, 1'b1);
  endtask

  // Reset held across one clock edge; outputs must drop to idle as soon as it asserts.
  task automatic do_reset();
    i_rst_n       = 1'b0;
    i_pix_valid   = 1'b0;
    i_frame_start = 1'b0;
    i_hs          = 1'b1;
    i_vs          = 1'b1;
    #1;
    check("rst_o_valid",  {31'd0, o_valid},     32'd0);
    check("rst_o_index",  {28'd0, o_index},     32'd0);
    check("rst_o_hs",     {31'd0, o_hs},        32'd1);
    check("rst_o_vs",     {31'd0, o_vs},        32'd1);
    check("rst_mem_rd",   {31'd0, mem_if.rd},   32'd0);
    check("rst_mem_addr", {20'd0, mem_if.addr}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n         = 1'b1;
    model_shadow    = 0;
    model_last_addr = 12'd0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(idle_entry());
  endtask

  initial begin
    i_rst_n       = 1'b1;
    i_frame_start = 1'b0;
    i_pix_valid   = 1'b0;
    i_x           = '0;
    i_y           = '0;
    i_hs          = 1'b1;
    i_vs          = 1'b1;
    i_scroll_x    = '0;
    for (int i = 0; i < 4096; i++) mem_arr[i] = 16'($urandom);
    mem_arr[0] = 16'h4321;
    #2;
    do_reset();

    // Unscrolled first line: indices 1,2,3,4 for each 8-pixel cell of word 0.
    step(1'b0, 0, 0, 1'b1, 16'd0, 1'b1, 1'b1);
    for (int x = 0; x < 32; x++) step(1'b1, x, 0, 1'b0, 16'd0, 1'b1, 1'b1);
    idle(3);

    // Scroll shadow: ignored without frame start, old value used in the frame-start cycle.
    step(1'b1, 0, 0, 1'b0, 16'd8, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b1, 16'd8, 1'b1, 1'b1);
    step(1'b1, 0, 0, 1'b0, 16'd8, 1'b1, 1'b1);
    step(1'b1, 0, 0, 1'b1, 16'd16, 1'b1, 1'b1);
    step(1'b1, 0, 0, 1'b0, 16'd16, 1'b1, 1'b1);
    idle(3);

    // Map edges: scroll past the right edge, then the last map row.
    step(1'b0, 0, 0, 1'b1, 16'd2040, 1'b1, 1'b1);
    step(1'b1, 8, 0, 1'b0, 16'd2040, 1'b1, 1'b1);
    step(1'b1, 0, 0, 1'b0, 16'd2040, 1'b1, 1'b1);
    step(1'b1, 639, 100, 1'b0, 16'd2040, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b1, 16'd0, 1'b1, 1'b1);
    step(1'b1, 0, 479, 1'b0, 16'd0, 1'b1, 1'b1);
    step(1'b1, 639, 479, 1'b0, 16'd0, 1'b1, 1'b1);
    idle(3);

    // Blanking with toggling syncs.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] pat;
      pat = 3'(i);
      step(1'b0, 0, 0, 1'b0, 16'd0, pat[0], pat[1]);
    end
    idle(3);

    // Reset mid-line with a non-zero shadow: pipeline flushed, shadow back to 0.
    step(1'b0, 0, 0, 1'b1, 16'd8, 1'b1, 1'b1);
    for (int x = 0; x < 6; x++) step(1'b1, x * 8, 0, 1'b0, 16'd8, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 0, 0, 1'b0, 16'd8, 1'b0, 1'b1);
    for (int x = 1; x < 5; x++) step(1'b1, x, 0, 1'b0, 16'd8, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic with occasional frame starts and large scrolls.
    for (int n = 0; n < 3000; n++) begin
      logic        v, fs, hs, vs;
      logic [15:0] sc;
      v  = ($urandom % 4) != 0;
      fs = ($urandom % 150) == 0;
      sc = (($urandom % 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047));
      hs = 1'($urandom);
      vs = 1'($urandom);
      step(v, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), fs, sc, hs, vs);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
